// File: rtl/nexys_starship_spawn_gen.sv
// Spawn generator feeding the four terminal monster SMs: shared timer_tick, per-terminal random
// spawn permission and a difficulty level. Optional level ramp enabled by SPAWN_LEVEL_RAMP_EN.
module nexys_starship_spawn_gen #(
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter logic [25:0] TICK_DIV    = 26'd50_000_000,
    parameter logic [3:0]  BASE_THRESH = 4'd4,
    parameter logic [3:0]  THRESH_STEP = 4'd3,
    parameter logic [7:0]  LEVEL_TICKS = 8'd20
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       play_flag,
    input  logic       gameover_ctrl,
    output logic       timer_tick,
    output logic       top_random,
    output logic       btm_random,
    output logic       left_random,
    output logic       right_random,
    output logic [1:0] level,
    output logic       q_SG_Idle,
    output logic       q_SG_Run,
    output logic       q_SG_Freeze
);

    localparam logic [2:0]  S_IDLE   = 3'b001;
    localparam logic [2:0]  S_RUN    = 3'b010;
    localparam logic [2:0]  S_FREEZE = 3'b100;
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [15:0] r_lfsr;
    logic        w_fb;
    logic [25:0] r_div_cnt;
    logic        w_run;
    logic        w_tick_ok;
    logic [3:0]  r_rand;
    logic [3:0]  w_rand_nxt;
    logic [1:0]  w_level;
    logic [5:0]  w_thresh6;
    logic [3:0]  w_thresh;

    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE:   w_state_nxt = (play_flag && !gameover_ctrl) ? S_RUN : S_IDLE;
            S_RUN:    w_state_nxt = gameover_ctrl ? S_FREEZE : S_RUN;
            S_FREEZE: w_state_nxt = play_flag ? S_FREEZE : S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    assign q_SG_Idle   = r_state[0];
    assign q_SG_Run    = r_state[1];
    assign q_SG_Freeze = r_state[2];

    // Free-running in every state so the spawn pattern depends on how long the player idled.
    assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge Clk) begin
        if (Reset) r_lfsr <= SEED_EFF;
        else       r_lfsr <= {r_lfsr[14:0], w_fb};
    end

    assign w_run      = (r_state == S_RUN);
    assign timer_tick = w_run && (r_div_cnt == TICK_DIV - 26'd1);
    assign w_tick_ok  = timer_tick && !gameover_ctrl;

    // Gameover wins over a coincident tick: the divider is parked and nothing else advances.
    always_ff @(posedge Clk) begin
        if (Reset || !w_run || gameover_ctrl) r_div_cnt <= 26'd0;
        else if (timer_tick)                  r_div_cnt <= 26'd0;
        else                                  r_div_cnt <= r_div_cnt + 26'd1;
    end

`ifdef SPAWN_LEVEL_RAMP_EN
    logic [7:0] r_lvl_cnt;
    logic [1:0] r_level;

    always_ff @(posedge Clk) begin
        if (Reset || w_state_nxt == S_IDLE) begin
            r_lvl_cnt <= 8'd0;
            r_level   <= 2'd0;
        end else if (w_tick_ok) begin
            if (r_lvl_cnt == LEVEL_TICKS - 8'd1) begin
                r_lvl_cnt <= 8'd0;
                if (r_level != 2'd3) r_level <= r_level + 2'd1;
            end else begin
                r_lvl_cnt <= r_lvl_cnt + 8'd1;
            end
        end
    end

    assign w_level = r_level;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^LEVEL_TICKS;
    assign w_level      = 2'd0;
`endif

    assign level = w_level;

    // Worst case 15 + 3*15 = 60 fits in 6 bits before saturating to a nibble.
    assign w_thresh6 = {2'b00, BASE_THRESH} + ({4'b0000, w_level} * {2'b00, THRESH_STEP});
    assign w_thresh  = (w_thresh6 > 6'd15) ? 4'd15 : w_thresh6[3:0];

    assign w_rand_nxt[0] = (r_lfsr[3:0]   < w_thresh);
    assign w_rand_nxt[1] = (r_lfsr[7:4]   < w_thresh);
    assign w_rand_nxt[2] = (r_lfsr[11:8]  < w_thresh);
    assign w_rand_nxt[3] = (r_lfsr[15:12] < w_thresh);

    always_ff @(posedge Clk) begin
        if (Reset || !w_run || gameover_ctrl) r_rand <= 4'd0;
        else if (timer_tick)                  r_rand <= w_rand_nxt;
    end

    assign top_random   = r_rand[0];
    assign btm_random   = r_rand[1];
    assign left_random  = r_rand[2];
    assign right_random = r_rand[3];

endmodule

// File: tb/tb_nexys_starship_spawn_gen.sv
// Scoreboard bench: a cycle-level reference model pushes expected outputs each Clk; the
// negedge checker pops and compares. A second instance exercises the zero-seed LFSR period.
module tb_nexys_starship_spawn_gen;

    localparam int          TD   = 4;
    localparam int          LT   = 3;
    localparam int          STEP = 3;
    localparam logic [15:0] SEED = 16'hACE1;
`ifdef SPAWN_LEVEL_RAMP_EN
    localparam logic [3:0]  BT      = 4'd4;
    localparam int          EXP_LVL = 3;
`else
    localparam logic [3:0]  BT      = 4'd15;
    localparam int          EXP_LVL = 0;
`endif

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       play_flag = 1'b0;
    logic       gameover_ctrl = 1'b0;
    logic       timer_tick, top_random, btm_random, left_random, right_random;
    logic [1:0] level;
    logic       q_SG_Idle, q_SG_Run, q_SG_Freeze;

    logic       z_tick, z_top, z_btm, z_left, z_right, z_idle, z_run, z_frz;
    logic [1:0] z_level;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    nexys_starship_spawn_gen #(
        .LFSR_SEED(SEED), .TICK_DIV(26'd4), .BASE_THRESH(BT),
        .THRESH_STEP(4'd3), .LEVEL_TICKS(8'd3)
    ) dut (
        .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .gameover_ctrl(gameover_ctrl),
        .timer_tick(timer_tick), .top_random(top_random), .btm_random(btm_random),
        .left_random(left_random), .right_random(right_random), .level(level),
        .q_SG_Idle(q_SG_Idle), .q_SG_Run(q_SG_Run), .q_SG_Freeze(q_SG_Freeze)
    );

    nexys_starship_spawn_gen #(
        .LFSR_SEED(16'h0000), .TICK_DIV(26'd4), .BASE_THRESH(4'd4),
        .THRESH_STEP(4'd3), .LEVEL_TICKS(8'd3)
    ) dut0 (
        .Clk(Clk), .Reset(Reset), .play_flag(1'b0), .gameover_ctrl(1'b0),
        .timer_tick(z_tick), .top_random(z_top), .btm_random(z_btm),
        .left_random(z_left), .right_random(z_right), .level(z_level),
        .q_SG_Idle(z_idle), .q_SG_Run(z_run), .q_SG_Freeze(z_frz)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: state 0=IDLE 1=RUN 2=FREEZE.
    int          m_st = 0, m_div = 0, m_lc = 0, m_lv = 0;
    logic [15:0] m_lfsr = SEED;
    logic [3:0]  m_rnd = 4'd0;
    logic [9:0]  sb_q[$];

    always @(posedge Clk) begin
        int          th, nst;
        logic        tick, tick_new;
        logic [15:0] l0;
        logic [9:0]  e;
        if (Reset) begin
            m_st = 0; m_div = 0; m_lc = 0; m_lv = 0; m_rnd = 4'd0; m_lfsr = SEED;
            e = 10'b001_00_0_0000;
        end else begin
            l0   = m_lfsr;
            tick = (m_st == 1) && (m_div == TD - 1);
            m_lfsr = {l0[14:0], l0[15] ^ l0[13] ^ l0[12] ^ l0[10]};
            nst = m_st;
            case (m_st)
                0:       if (play_flag && !gameover_ctrl) nst = 1;
                1:       if (gameover_ctrl) nst = 2;
                default: if (!play_flag) nst = 0;
            endcase
            if (m_st == 1 && nst == 1) begin
                m_div = tick ? 0 : m_div + 1;
                if (tick) begin
                    th = int'(BT) + m_lv * STEP;
                    if (th > 15) th = 15;
                    for (int i = 0; i < 4; i++) m_rnd[i] = (int'((l0 >> (4 * i)) & 16'hF) < th);
`ifdef SPAWN_LEVEL_RAMP_EN
                    if (m_lc == LT - 1) begin
                        m_lc = 0;
                        if (m_lv < 3) m_lv++;
                    end else m_lc++;
`endif
                end
            end else begin
                m_div = 0;
                m_rnd = 4'd0;
            end
            if (nst == 0) begin m_lc = 0; m_lv = 0; end
            m_st = nst;
            tick_new = (m_st == 1) && (m_div == TD - 1);
            e = {m_st == 2, m_st == 1, m_st == 0, 2'(m_lv), tick_new, m_rnd[3], m_rnd[2], m_rnd[1], m_rnd[0]};
        end
        sb_q.push_back(e);
    end

    always @(negedge Clk) begin
        logic [9:0] e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("outs", {q_SG_Freeze, q_SG_Run, q_SG_Idle, level, timer_tick,
                         right_random, left_random, btm_random, top_random}, e);
        end
    end

    initial begin
        int n_tick, first, zeros, early;
        // Reset and idle
        repeat (3) @(negedge Clk);
        chk("rst_outs", {q_SG_Freeze, q_SG_Run, q_SG_Idle, level, timer_tick,
                         right_random, left_random, btm_random, top_random}, 10'b001_00_0_0000);
        Reset = 1'b0;
        @(negedge Clk);
        chk("idle_hold", q_SG_Idle, 1);

        // Enter RUN; count ticks and watch level ramp
        play_flag = 1'b1;
        @(negedge Clk);
        chk("run_entry", q_SG_Run, 1);
        n_tick = 0; first = -1;
        for (int k = 1; k <= 80; k++) begin
            if (k > 1) @(negedge Clk);
            if (timer_tick) begin
                n_tick++;
                if (first < 0) first = k;
            end
            if (k == 40) begin
                chk("ticks_40", n_tick, 10);
                chk("level_40", level, EXP_LVL);
            end
        end
        chk("first_tick", first, TD);
        chk("ticks_80", n_tick, 20);
        chk("level_80", level, EXP_LVL);

        // Gameover coincident with a tick
        chk("tick_at_go", timer_tick, 1);
        gameover_ctrl = 1'b1;
        @(negedge Clk);
        chk("freeze", q_SG_Freeze, 1);
        chk("frz_rand", {right_random, left_random, btm_random, top_random}, 0);
        chk("frz_level", level, EXP_LVL);
        n_tick = 0;
        repeat (8) begin
            @(negedge Clk);
            if (timer_tick) n_tick++;
        end
        chk("frz_ticks", n_tick, 0);
        gameover_ctrl = 1'b0;
        play_flag = 1'b0;
        @(negedge Clk);
        chk("back_idle", q_SG_Idle, 1);
        chk("idle_level", level, 0);

        // Reset mid-RUN with div_cnt==2
        play_flag = 1'b1;
        @(negedge Clk);
        chk("run_again", q_SG_Run, 1);
        repeat (14) @(negedge Clk);
        chk("div_pre", dut.r_div_cnt, 2);
        Reset = 1'b1;
        @(negedge Clk);
        chk("mid_rst", {q_SG_Freeze, q_SG_Run, q_SG_Idle, level, timer_tick,
                        right_random, left_random, btm_random, top_random}, 10'b001_00_0_0000);
        chk("lfsr_seed", dut.r_lfsr, 16'hACE1);
        chk("lfsr0_seed", dut0.r_lfsr, 16'h0001);
        play_flag = 1'b0;
        Reset = 1'b0;

        // Zero seed: full maximal-length period
        zeros = 0; early = 0;
        for (int i = 1; i <= 65535; i++) begin
            @(negedge Clk);
            if (dut0.r_lfsr == 16'h0000) zeros++;
            if (dut0.r_lfsr == 16'h0001 && i < 65535) early++;
        end
        chk("lfsr_zero", zeros, 0);
        chk("lfsr_early", early, 0);
        chk("lfsr_period", dut0.r_lfsr, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
